permutation_ctrl: RTL and testbench

PERMUTATION_CTRL -- requirements
Module: permutation_ctrl

---
 rtl/permutation_ctrl.sv | 172 +++++++++++++++++
 tb/tb_permutation_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/permutation_ctrl.sv
// -----------------------------------------------------------------------------
// ascon_pack : constants shared by the Ascon permutation datapath and control.
//
// permutation_ctrl : sequencer for one Ascon permutation (pa or pb).
//   clock_i   in   1  rising-edge clock
//   reset_i   in   1  asynchronous active-high reset
//   start_i   in   1  request to run one permutation
//   rounds_i  in   2  round select: 00/11 = 12, 01 = 6, 10 = 8 rounds
//   round_o   out  4  round index for the constant-addition layer
//   select_o  out  1  datapath mux: 1 = external state, 0 = feedback
//   en_reg_o  out  1  state-register capture enable
//   busy_o    out  1  permutation in progress (INIT or RUN)
//   done_o    out  1  one-cycle pulse, state register holds the result
//
// The FSM is Moore: every output is a flop loaded from the decode of the
// next state and next counter, so each output always equals the decode of
// the current state/counter and no path runs from start_i to an output.
// -----------------------------------------------------------------------------
package ascon_pack;

    // Index of the final round; every permutation ends here.
    localparam logic [3:0] ROUND_LAST = 4'd11;

    // First round index for a round select; shorter permutations run the
    // tail of the 12-round constant schedule.
    function automatic logic [3:0] start_index(input logic [1:0] sel);
        logic [3:0] idx;
        case (sel)
            2'b01:   idx = 4'd6;
            2'b10:   idx = 4'd4;
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

endpackage

module permutation_ctrl
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [1:0] rounds_i,
    output logic [3:0] round_o,
    output logic       select_o,
    output logic       en_reg_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0] state_r;
    logic [3:0] cnt_r;
    logic [1:0] rounds_r;

    logic [1:0] next_state_s;
    logic [3:0] next_cnt_s;
    logic [1:0] next_rounds_s;

    logic [3:0] next_round_s;
    logic       next_select_s;
    logic       next_en_reg_s;
    logic       next_busy_s;
    logic       next_done_s;

    // Next-state, round counter and round-select latch.
    always_comb begin
        next_state_s  = state_r;
        next_cnt_s    = cnt_r;
        next_rounds_s = rounds_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    next_state_s  = ST_INIT;
                    next_rounds_s = rounds_i;
                    next_cnt_s    = start_index(rounds_i);
                end else begin
                    next_cnt_s = 4'd0;
                end
            end
            ST_INIT: begin
                // The counter already holds start_index(rounds_r).
                next_state_s = ST_RUN;
                next_cnt_s   = start_index(rounds_r) + 4'd1;
            end
            ST_RUN: begin
                // Saturate at the last round so the counter never wraps.
                if (cnt_r >= ROUND_LAST) begin
                    next_state_s = ST_DONE;
                    next_cnt_s   = ROUND_LAST;
                end else begin
                    next_cnt_s = cnt_r + 4'd1;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    next_state_s  = ST_INIT;
                    next_rounds_s = rounds_i;
                    next_cnt_s    = start_index(rounds_i);
                end else begin
                    next_state_s = ST_IDLE;
                    next_cnt_s   = 4'd0;
                end
            end
            default: begin
                next_state_s  = ST_IDLE;
                next_cnt_s    = 4'd0;
                next_rounds_s = 2'b00;
            end
        endcase
    end

    // Output decode of the next state, loaded into the output flops below.
    always_comb begin
        next_round_s  = 4'd0;
        next_select_s = 1'b0;
        next_en_reg_s = 1'b0;
        next_busy_s   = 1'b0;
        next_done_s   = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                next_round_s = 4'd0;
            end
            ST_INIT: begin
                next_round_s  = next_cnt_s;
                next_select_s = 1'b1;
                next_en_reg_s = 1'b1;
                next_busy_s   = 1'b1;
            end
            ST_RUN: begin
                next_round_s  = next_cnt_s;
                next_en_reg_s = 1'b1;
                next_busy_s   = 1'b1;
            end
            ST_DONE: begin
                next_done_s = 1'b1;
            end
            default: begin
                next_round_s = 4'd0;
            end
        endcase
    end

    // State, counter, latched round select and registered outputs.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            rounds_r <= 2'b00;
            round_o  <= 4'd0;
            select_o <= 1'b0;
            en_reg_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= next_cnt_s;
            rounds_r <= next_rounds_s;
            round_o  <= next_round_s;
            select_o <= next_select_s;
            en_reg_o <= next_en_reg_s;
            busy_o   <= next_busy_s;
            done_o   <= next_done_s;
        end
    end

endmodule

// File: tb/tb_permutation_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for permutation_ctrl. Expected output vectors
// {round, select, en_reg, busy, done} are pushed to a scoreboard queue as
// stimulus is driven and popped/compared once per cycle, #1 after the edge.
// -----------------------------------------------------------------------------
module tb_permutation_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] rounds;
    logic [3:0] round;
    logic       sel;
    logic       en_reg;
    logic       busy;
    logic       done;

    logic [7:0] sb[$];
    int         compares;
    int         fails;

    permutation_ctrl dut (
        .clock_i  (clk),
        .reset_i  (rst),
        .start_i  (start),
        .rounds_i (rounds),
        .round_o  (round),
        .select_o (sel),
        .en_reg_o (en_reg),
        .busy_o   (busy),
        .done_o   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] vec(input logic [3:0] r, input logic s,
                                       input logic e, input logic b,
                                       input logic d);
        return {r, s, e, b, d};
    endfunction

    function automatic int n_rounds(input logic [1:0] r);
        case (r)
            2'b01:   return 6;
            2'b10:   return 8;
            default: return 12;
        endcase
    endfunction

    task automatic push_idle();
        sb.push_back(vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // INIT, RUN rounds, DONE for one permutation of the given select.
    task automatic push_op(input logic [1:0] r);
        int first;
        first = 12 - n_rounds(r);
        sb.push_back(vec(4'(first), 1'b1, 1'b1, 1'b1, 1'b0));
        for (int k = first + 1; k <= 11; k++)
            sb.push_back(vec(4'(k), 1'b0, 1'b1, 1'b1, 1'b0));
        sb.push_back(vec(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic check_now(input string tag);
        logic [7:0] exp_v;
        logic [7:0] obs_v;
        compares++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed %h", tag,
                   {round, sel, en_reg, busy, done});
        end else begin
            exp_v = sb.pop_front();
            obs_v = {round, sel, en_reg, busy, done};
            assert (obs_v === exp_v) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h (round,sel,en,busy,done)",
                       tag, obs_v, exp_v);
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    // One permutation from a single start pulse; rounds_i is disturbed after
    // acceptance and, with noise set, start_i toggles while the op runs.
    task automatic run_single(input logic [1:0] r, input bit noise, input string tag);
        int n;
        n = n_rounds(r);
        start  = 1'b1;
        rounds = r;
        push_op(r);
        tick({tag, "_init"});
        start  = 1'b0;
        rounds = ~r;
        for (int i = 1; i <= n; i++) begin
            if (noise) start = 1'($urandom_range(0, 1));
            tick({tag, "_run"});
        end
        start = 1'b0;
        push_idle();
        tick({tag, "_idle"});
    endtask

    initial begin
        compares = 0;
        fails    = 0;
        rst      = 1'b0;
        start    = 1'b0;
        rounds   = 2'b00;

        // Reset acts without a clock edge.
        #1 rst = 1'b1;
        #1;
        push_idle();
        check_now("reset_async");
        push_idle();
        tick("reset_edge");

        // Start in the same cycle reset is released.
        rst = 1'b0;
        run_single(2'b00, 1'b0, "r12_first");
        run_single(2'b01, 1'b1, "r6_noise");
        run_single(2'b10, 1'b1, "r8_noise");
        run_single(2'b11, 1'b0, "r12_sel11");
        run_single(2'b00, 1'b1, "r12_noise");

        // Back-to-back: start held high, DONE goes straight to INIT.
        start  = 1'b1;
        rounds = 2'b01;
        for (int k = 0; k < 3; k++) push_op(2'b01);
        for (int i = 0; i < 21; i++) tick("b2b");
        start = 1'b0;
        push_idle();
        tick("b2b_idle");

        // Reset in the middle of a 12-round permutation.
        start  = 1'b1;
        rounds = 2'b00;
        sb.push_back(vec(4'd0, 1'b1, 1'b1, 1'b1, 1'b0));
        tick("abort_init");
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            sb.push_back(vec(4'(k), 1'b0, 1'b1, 1'b1, 1'b0));
            tick("abort_run");
        end
        #2 rst = 1'b1;
        #1;
        push_idle();
        check_now("abort_async");
        for (int i = 0; i < 2; i++) begin
            push_idle();
            tick("abort_hold");
        end
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            push_idle();
            tick("abort_no_done");
        end
        run_single(2'b00, 1'b0, "after_abort");

        compares++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
